// File: rtl/user_rom_streamer.sv
// Fetches up to MaxWords 32-bit words over an OBI read-only manager port and
// streams their bytes little-endian until a NUL byte, the word limit, or a bus error.

package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic        a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;
endpackage

module user_rom_streamer #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       MaxWords  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [ObiCfg.AddrWidth-1:0] base_addr_i,
    output obi_req_t                    obi_req_o,
    input  obi_rsp_t                    obi_rsp_i,
    output logic [7:0]                  byte_o,
    output logic                        byte_valid_o,
    input  logic                        byte_ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int unsigned AW   = ObiCfg.AddrWidth;
    localparam int unsigned IdxW = (MaxWords > 1) ? $clog2(MaxWords) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxWords - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [IdxW-1:0] idx_q;
    logic [31:0]     word_q;
    logic [1:0]      lane_q;
    logic            err_q;
    logic [7:0]      cur_byte;
    logic            byte_xfer;
    logic            unused_rsp;

    assign unused_rsp = ^{obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    assign cur_byte  = 8'(word_q >> {lane_q, 3'b000});
    assign byte_xfer = (state_q == S_DRAIN) && (cur_byte != 8'h00) && byte_ready_i;

    assign byte_o = cur_byte;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_REQ;
            end
            S_REQ: begin
                if (obi_rsp_i.gnt) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (obi_rsp_i.rvalid) state_d = obi_rsp_i.r.err ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                // A NUL terminates the string and is never presented downstream.
                if (cur_byte == 8'h00) begin
                    state_d = S_DONE;
                end else begin
                    byte_valid_o = 1'b1;
                    if (byte_ready_i && (lane_q == 2'd3)) begin
                        state_d = (idx_q == LastIdx) ? S_DONE : S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        obi_req_o            = '0;
        obi_req_o.req        = (state_q == S_REQ);
        obi_req_o.a.addr     = addr_q;
        obi_req_o.a.we       = 1'b0;
        obi_req_o.a.be       = 4'hF;
        obi_req_o.a.wdata    = '0;
        obi_req_o.a.aid      = '0;
        obi_req_o.a.a_optional = '0;
    end

    // Word address advances by 4 per fetched word and wraps with the adder width.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            idx_q  <= '0;
            word_q <= '0;
            lane_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q <= base_addr_i;
                        idx_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_WAIT_R: begin
                    if (obi_rsp_i.rvalid) begin
                        if (obi_rsp_i.r.err) begin
                            err_q <= 1'b1;
                        end else begin
                            word_q <= obi_rsp_i.r.rdata[31:0];
                            lane_q <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (byte_xfer) begin
                        lane_q <= lane_q + 2'd1;
                        if ((lane_q == 2'd3) && (idx_q != LastIdx)) begin
                            idx_q  <= idx_q + IdxW'(1);
                            addr_q <= addr_q + AW'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
